// File: rtl/hazard_control_unit_if.sv
// Cache handshake bundle between the pipeline front/back end and the
// hazard_control_unit. The master side raises requests and returns
// responses; the slave side (the hazard unit) returns gated requests.
interface hazard_control_unit_if;
  logic icache_req;
  logic icache_resp;
  logic icache_read_en;
  logic dcache_req;
  logic dcache_resp;
  logic dcache_req_en;
  logic dcache_rdata_capture;

  modport master (
    output icache_req,
    output icache_resp,
    output dcache_req,
    output dcache_resp,
    input  icache_read_en,
    input  dcache_req_en,
    input  dcache_rdata_capture
  );

  modport slave (
    input  icache_req,
    input  icache_resp,
    input  dcache_req,
    input  dcache_resp,
    output icache_read_en,
    output dcache_req_en,
    output dcache_rdata_capture
  );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use bubbles, I/D-cache miss freezes and taken-branch
// redirects, and remembers which cache already answered during a freeze so
// that it is not asked again before the pipeline advances.
// Optional feature: define HAZARD_PERF_CNT_EN to build the performance
// counters; otherwise the counter outputs are tied to zero.
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_control_unit_if.slave cache,
  input  logic                 id_ex_mem_read,
  input  logic [4:0]           id_ex_rd,
  input  logic [4:0]           if_id_rs1,
  input  logic [4:0]           if_id_rs2,
  input  logic                 using_rs1,
  input  logic                 using_rs2,
  input  logic                 br_taken,
  output logic                 pc_load,
  output logic                 if_id_load,
  output logic                 id_ex_load,
  output logic                 ex_mem_load,
  output logic                 mem_wb_load,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 stall_active,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     bubble_count,
  output logic [CNT_W-1:0]     flush_count
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t state;
  state_t state_next;
  logic   i_done;
  logic   d_done;
  logic   i_pend;
  logic   d_pend;
  logic   advance;
  logic   load_use;
  logic   is_redirect;
  logic   is_bubble;

  // Stall FSM state register: RUN while advancing, WAIT while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Sticky "already answered" bits: a response seen during a freeze is
  // remembered until the pipeline finally advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (advance) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (cache.icache_resp) i_done <= 1'b1;
      if (cache.dcache_resp) d_done <= 1'b1;
    end
  end

  // Completion terms, hazard detection, next state and all per-cycle
  // pipeline controls; everything is forced low while reset is held.
  always_comb begin
    i_pend      = cache.icache_req & ~cache.icache_resp & ~i_done;
    d_pend      = cache.dcache_req & ~cache.dcache_resp & ~d_done;
    advance     = ~i_pend & ~d_pend;
    load_use    = id_ex_mem_read & (id_ex_rd != 5'd0) &
                  ((using_rs1 & (id_ex_rd == if_id_rs1)) |
                   (using_rs2 & (id_ex_rd == if_id_rs2)));
    is_redirect = advance & br_taken;
    is_bubble   = advance & ~br_taken & load_use;

    state_next = RUN;
    case (state)
      RUN:     state_next = advance ? RUN : WAIT;
      WAIT:    state_next = advance ? RUN : WAIT;
      default: state_next = RUN;
    endcase

    pc_load                    = 1'b0;
    if_id_load                 = 1'b0;
    id_ex_load                 = 1'b0;
    ex_mem_load                = 1'b0;
    mem_wb_load                = 1'b0;
    if_id_flush                = 1'b0;
    id_ex_flush                = 1'b0;
    stall_active               = 1'b0;
    cache.icache_read_en       = 1'b0;
    cache.dcache_req_en        = 1'b0;
    cache.dcache_rdata_capture = 1'b0;

    if (!rst) begin
      cache.icache_read_en       = cache.icache_req & ~i_done;
      cache.dcache_req_en        = cache.dcache_req & ~d_done;
      cache.dcache_rdata_capture = cache.dcache_resp & cache.dcache_req & ~d_done;
      stall_active               = ~advance;

      if (is_redirect) begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (is_bubble) begin
        id_ex_load  = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
      end else if (advance) begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Performance counters: frozen cycles, load-use bubbles and redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (!advance)    stall_cycles <= stall_cycles + 1'b1;
      if (is_bubble)   bubble_count <= bubble_count + 1'b1;
      if (is_redirect) flush_count  <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign bubble_count = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed testbench for hazard_control_unit: load-use bubbles, x0 loads,
// D-miss freeze, overlapping I/D misses, redirect during a freeze and an
// asynchronous reset in the middle of a miss.
module tb_hazard_control_unit;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc, if_id, id_ex, ex_mem, mem_wb loads, if_id_flush, id_ex_flush}
  localparam logic [6:0] FRZ  = 7'b00000_00;
  localparam logic [6:0] RUNV = 7'b11111_00;
  localparam logic [6:0] BUB  = 7'b00111_01;
  localparam logic [6:0] RDR  = 7'b11111_11;

  logic        clk;
  logic        rst;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rd;
  logic [4:0]  if_id_rs1;
  logic [4:0]  if_id_rs2;
  logic        using_rs1;
  logic        using_rs2;
  logic        br_taken;
  logic        pc_load;
  logic        if_id_load;
  logic        id_ex_load;
  logic        ex_mem_load;
  logic        mem_wb_load;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        stall_active;
  logic [31:0] stall_cycles;
  logic [31:0] bubble_count;
  logic [31:0] flush_count;

  int vectors;
  int miscompares;

  hazard_control_unit_if cache_bus ();

  hazard_control_unit #(.CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .cache          (cache_bus),
    .id_ex_mem_read (id_ex_mem_read),
    .id_ex_rd       (id_ex_rd),
    .if_id_rs1      (if_id_rs1),
    .if_id_rs2      (if_id_rs2),
    .using_rs1      (using_rs1),
    .using_rs2      (using_rs2),
    .br_taken       (br_taken),
    .pc_load        (pc_load),
    .if_id_load     (if_id_load),
    .id_ex_load     (id_ex_load),
    .ex_mem_load    (ex_mem_load),
    .mem_wb_load    (mem_wb_load),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .stall_active   (stall_active),
    .stall_cycles   (stall_cycles),
    .bubble_count   (bubble_count),
    .flush_count    (flush_count)
  );

  // Free-running pipeline clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] ctl_vec();
    return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
            if_id_flush, id_ex_flush};
  endfunction

  // {icache_read_en, dcache_req_en, dcache_rdata_capture, stall_active}
  function automatic logic [3:0] cache_vec();
    return {cache_bus.icache_read_en, cache_bus.dcache_req_en,
            cache_bus.dcache_rdata_capture, stall_active};
  endfunction

  task automatic apply_stimulus(input logic mem_read, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic br);
    id_ex_mem_read = mem_read;
    id_ex_rd       = rd;
    if_id_rs1      = rs1;
    if_id_rs2      = rs2;
    using_rs1      = u1;
    using_rs2      = u2;
    br_taken       = br;
  endtask

  task automatic set_cache(input logic ireq, input logic iresp,
                           input logic dreq, input logic dresp);
    cache_bus.icache_req  = ireq;
    cache_bus.icache_resp = iresp;
    cache_bus.dcache_req  = dreq;
    cache_bus.dcache_resp = dresp;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_cache(1'b1, 1'b0, 1'b1, 1'b1);

    // Reset holds every control low even with requests/responses present.
    @(negedge clk);
    check_output("reset_ctl", 32'(ctl_vec()), 32'(FRZ));
    check_output("reset_cache", 32'(cache_vec()), 32'h0);
    check_output("reset_stall_cnt", stall_cycles, 32'd0);

    // First cycle after reset release advances normally.
    next_cycle();
    rst = 1'b0;
    set_cache(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("idle_ctl", 32'(ctl_vec()), 32'(RUNV));
    check_output("idle_cache", 32'(cache_vec()), 32'h0);

    // Load-use on rs1 gives one bubble, then normal flow.
    next_cycle();
    apply_stimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("lu_rs1_ctl", 32'(ctl_vec()), 32'(BUB));
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("lu_after_ctl", 32'(ctl_vec()), 32'(RUNV));
    check_output("lu_bubble_cnt", bubble_count, PERF ? 32'd1 : 32'd0);

    // Load to x0 never creates a hazard.
    next_cycle();
    apply_stimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_output("lu_x0_ctl", 32'(ctl_vec()), 32'(RUNV));

    // Load-use through rs2.
    next_cycle();
    apply_stimulus(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("lu_rs2_ctl", 32'(ctl_vec()), 32'(BUB));

    // Register match but the source is not actually read.
    next_cycle();
    apply_stimulus(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("lu_unused_ctl", 32'(ctl_vec()), 32'(RUNV));
    check_output("lu2_bubble_cnt", bubble_count, PERF ? 32'd2 : 32'd0);

    // D-miss: four frozen cycles, response cycle advances and captures.
    for (int k = 0; k <= 4; k++) begin
      next_cycle();
      apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      set_cache(1'b0, 1'b0, 1'b1, (k == 4));
      @(negedge clk);
      check_output($sformatf("dmiss_ctl_%0d", k), 32'(ctl_vec()),
                   32'((k < 4) ? FRZ : RUNV));
      check_output($sformatf("dmiss_cache_%0d", k), 32'(cache_vec()),
                   (k < 4) ? 32'b0101 : 32'b0110);
    end
    next_cycle();
    set_cache(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("dmiss_stall_cnt", stall_cycles, PERF ? 32'd4 : 32'd0);

    // Overlapping misses: I answers at 2, D answers at 6.
    for (int k = 0; k <= 8; k++) begin
      next_cycle();
      set_cache(1'b1, (k == 2 || k == 8), (k <= 6), (k == 6));
      @(negedge clk);
      check_output($sformatf("ovl_iread_%0d", k), 32'(cache_bus.icache_read_en),
                   (k <= 2 || k >= 7) ? 32'd1 : 32'd0);
      check_output($sformatf("ovl_stall_%0d", k), 32'(stall_active),
                   (k <= 5 || k == 7) ? 32'd1 : 32'd0);
      check_output($sformatf("ovl_ctl_%0d", k), 32'(ctl_vec()),
                   32'((k <= 5 || k == 7) ? FRZ : RUNV));
    end
    next_cycle();
    set_cache(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("ovl_stall_cnt", stall_cycles, PERF ? 32'd11 : 32'd0);

    // Redirect held during a D freeze (with a load-use also present).
    for (int k = 0; k <= 3; k++) begin
      next_cycle();
      apply_stimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
      set_cache(1'b0, 1'b0, 1'b1, (k == 3));
      @(negedge clk);
      check_output($sformatf("rdr_ctl_%0d", k), 32'(ctl_vec()),
                   32'((k < 3) ? FRZ : RDR));
    end
    next_cycle();
    apply_stimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    set_cache(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("rdr_after_ctl", 32'(ctl_vec()), 32'(RUNV));
    check_output("rdr_flush_cnt", flush_count, PERF ? 32'd1 : 32'd0);
    check_output("rdr_bubble_cnt", bubble_count, PERF ? 32'd2 : 32'd0);
    check_output("rdr_stall_cnt", stall_cycles, PERF ? 32'd14 : 32'd0);

    // Async reset in the middle of a miss with i_done set.
    next_cycle();
    set_cache(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_output("rstmid_c0_cache", 32'(cache_vec()), 32'b1101);
    next_cycle();
    set_cache(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_output("rstmid_c1_cache", 32'(cache_vec()), 32'b0101);
    rst = 1'b1;
    #1;
    check_output("rstmid_ctl", 32'(ctl_vec()), 32'(FRZ));
    check_output("rstmid_cache", 32'(cache_vec()), 32'h0);
    check_output("rstmid_stall_cnt", stall_cycles, 32'd0);
    check_output("rstmid_flush_cnt", flush_count, 32'd0);
    next_cycle();
    rst = 1'b0;
    set_cache(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("postrst_cache", 32'(cache_vec()), 32'b1001);
    check_output("postrst_ctl", 32'(ctl_vec()), 32'(FRZ));
    next_cycle();
    set_cache(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("postrst_resp_cache", 32'(cache_vec()), 32'b1000);
    check_output("postrst_resp_ctl", 32'(ctl_vec()), 32'(RUNV));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
